// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage memory sequencer: FSM state encoding
// and the default access timeout.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } mem_state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Cycle counter bounding how long an access may sit in REQ+WAIT_R.
// Saturates at the last count so expiry stays asserted until cleared.
module mem_timeout_cnt #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST_CNT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST_CNT);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: issues each load/store once over req/gnt/rvalid,
// stalls upstream stages while the access is outstanding, and gates write-back.
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [31:0] ex_aluresult,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memtoreg,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] wb_aluresult,
  output logic [31:0] wb_memreadresult,
  output logic [4:0]  wb_rd,
  output logic        wb_regwrite,
  output logic        wb_memtoreg,
  output logic        stall,
  output logic        err
);

  mem_state_e  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        abort_q, abort_d;

  logic mem_req_c;
  logic stall_c;
  logic wb_regwrite_c;
  logic expired;

  logic mem_op;
  logic illegal_op;
  mem_state_e granted_state;

  assign mem_op        = ex_memread | ex_memwrite;
  assign illegal_op    = ex_memread & ex_memwrite;
  // An illegal read+write combination is carried out as a read.
  assign granted_state = ex_memread ? WAIT_R : RESP;

  mem_timeout_cnt #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state_q == IDLE) || (state_q == RESP)),
    .enable ((state_q == REQ) || (state_q == WAIT_R)),
    .expired(expired)
  );

  always_comb begin
    state_d       = state_q;
    rdata_d       = rdata_q;
    err_d         = 1'b0;
    abort_d       = abort_q;
    mem_req_c     = 1'b0;
    stall_c       = 1'b0;
    wb_regwrite_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          mem_req_c = 1'b1;
          stall_c   = 1'b1;
          err_d     = illegal_op;
          state_d   = mem_gnt ? granted_state : REQ;
        end else begin
          wb_regwrite_c = ex_regwrite;
        end
      end
      REQ: begin
        mem_req_c = 1'b1;
        stall_c   = 1'b1;
        if (mem_gnt) begin
          state_d = granted_state;
        end else if (expired) begin
          state_d = RESP;
          abort_d = 1'b1;
          err_d   = 1'b1;
        end
      end
      WAIT_R: begin
        stall_c = 1'b1;
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else if (expired) begin
          state_d = RESP;
          abort_d = 1'b1;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        // The op still held in EX/MEM here was already issued; just retire it.
        wb_regwrite_c = ex_regwrite & ~abort_q;
        state_d       = IDLE;
        abort_d       = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  assign mem_req          = mem_req_c & ~rst;
  assign mem_we           = mem_req & ex_memwrite & ~ex_memread;
  assign mem_addr         = ex_aluresult;
  assign mem_wdata        = ex_wdata;
  assign stall            = stall_c & ~rst;
  assign wb_regwrite      = wb_regwrite_c & ~rst;
  assign wb_aluresult     = ex_aluresult;
  assign wb_memreadresult = rdata_q;
  assign wb_rd            = ex_rd;
  assign wb_memtoreg      = ex_memtoreg;
  assign err              = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: each transaction pushes its predicted
// completion, which is popped and compared when stall drops.
module tb_mem_stage_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg;
  logic [31:0] ex_aluresult, ex_wdata;
  logic [4:0]  ex_rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] wb_aluresult, wb_memreadresult;
  logic [4:0]  wb_rd;
  logic        wb_regwrite, wb_memtoreg, stall, err;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_aluresult(ex_aluresult), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_aluresult(wb_aluresult), .wb_memreadresult(wb_memreadresult),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .stall(stall), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          resp;
    logic        regwrite;
    logic        memtoreg;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    int          reqs;
    int          hs;
    int          errs;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_rdata = '0;

  task automatic set_bubble();
    ex_memread   = 1'b0;
    ex_memwrite  = 1'b0;
    ex_regwrite  = 1'b0;
    ex_memtoreg  = 1'b0;
    ex_aluresult = '0;
    ex_wdata     = '0;
    ex_rd        = '0;
  endtask

  // g/r: cycle of gnt/rvalid relative to issue (99 = never). stray adds an
  // rvalid with junk data on the gnt cycle and a gnt on the rvalid cycle.
  task automatic run_op(input string tag, input logic rd_op, input logic wr_op,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input logic regwrite,
                        input int g, input int r, input logic [31:0] rdata,
                        input logic stray);
    exp_t e;
    exp_t got_e;
    int   ev;
    logic abort;
    logic memop;
    bit   done;
    int   reqs, hs, errs, resp_c;
    memop = rd_op | wr_op;
    abort = 1'b0;
    reqs = 0; hs = 0; errs = 0; resp_c = -1;
    e.resp = 0; e.reqs = 0; e.hs = 0; e.errs = 0;
    if (memop) begin
      ev     = rd_op ? ((g <= TO) ? r : 1000) : g;
      abort  = (ev > TO);
      e.resp = abort ? TO + 1 : ev + 1;
      e.reqs = (g <= TO) ? g + 1 : TO + 1;
      e.hs   = (g <= TO) ? 1 : 0;
      e.errs = ((rd_op && wr_op) ? 1 : 0) + (abort ? 1 : 0);
      if (rd_op && !abort) model_rdata = rdata;
    end
    e.regwrite = regwrite & ~abort;
    e.memtoreg = rd_op;
    e.rd       = rd;
    e.alu      = addr;
    e.rdata    = model_rdata;
    sb_q.push_back(e);

    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        ex_memread   = rd_op;
        ex_memwrite  = wr_op;
        ex_aluresult = addr;
        ex_wdata     = wdata;
        ex_rd        = rd;
        ex_regwrite  = regwrite;
        ex_memtoreg  = rd_op;
      end
      mem_gnt    = (c == g) || (stray && c == r);
      mem_rvalid = (c == r) || (stray && c == g);
      mem_rdata  = (c == r) ? rdata : 32'hDEAD_BEEF;
      @(negedge clk);
      if (mem_req) begin
        reqs++;
        if (mem_gnt) hs++;
        check({tag, "_we"}, mem_we, wr_op & ~rd_op);
        check({tag, "_addr"}, mem_addr, addr);
        check({tag, "_wdata"}, mem_wdata, wdata);
      end
      if (err) errs++;
      if (!stall) begin
        done   = 1;
        resp_c = c;
      end else begin
        check({tag, "_bubble"}, wb_regwrite, 1'b0);
      end
    end

    got_e = sb_q.pop_front();
    if (!done) begin
      check({tag, "_complete"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_resp_cycle"}, resp_c, got_e.resp);
      check({tag, "_regwrite"}, wb_regwrite, got_e.regwrite);
      check({tag, "_memtoreg"}, wb_memtoreg, got_e.memtoreg);
      check({tag, "_rd"}, wb_rd, got_e.rd);
      check({tag, "_alu"}, wb_aluresult, got_e.alu);
      check({tag, "_rdata"}, wb_memreadresult, got_e.rdata);
      check({tag, "_req_cycles"}, reqs, got_e.reqs);
      check({tag, "_handshakes"}, hs, got_e.hs);
      check({tag, "_err_pulses"}, errs, got_e.errs);
    end
    $display("txn %-10s resp_cycle=%0d reqs=%0d handshakes=%0d err_pulses=%0d rdata=0x%08h",
             tag, resp_c, reqs, hs, errs, wb_memreadresult);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    set_bubble();
    ex_memread  = 1'b1;
    ex_regwrite = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", stall, 1'b0);
    check("rst_req", mem_req, 1'b0);
    check("rst_regwrite", wb_regwrite, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rdata", wb_memreadresult, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_bubble();
    @(negedge clk);
    check("idle_stall", stall, 1'b0);
    check("idle_req", mem_req, 1'b0);
    $display("txn %-10s reset released", "reset");

    run_op("alu",      0, 0, 32'h0000_1234, 32'h0,         5'd5,  1, 0,  0,  32'hDEAD_0001, 1);
    run_op("load",     1, 0, 32'h0000_0100, 32'h0,         5'd7,  1, 0,  3,  32'hCAFE_F00D, 0);
    run_op("store",    0, 1, 32'h0000_0040, 32'h1234_5678, 5'd0,  0, 2,  99, 32'h0,         0);
    run_op("ld_tmo",   1, 0, 32'h0000_0200, 32'h0,         5'd9,  1, 0,  99, 32'h0,         0);
    run_op("alu2",     0, 0, 32'h0000_0055, 32'h0,         5'd3,  1, 99, 99, 32'h0,         0);
    run_op("ld_b2b_a", 1, 0, 32'h0000_0300, 32'h0,         5'd10, 1, 1,  3,  32'hA1A1_A1A1, 1);
    run_op("ld_b2b_b", 1, 0, 32'h0000_0304, 32'h0,         5'd11, 1, 0,  1,  32'hB2B2_B2B2, 0);
    run_op("illegal",  1, 1, 32'h0000_0400, 32'h0000_FFFF, 5'd12, 1, 0,  2,  32'h0BAD_0BAD, 0);
    run_op("st_tmo",   0, 1, 32'h0000_0044, 32'h0000_0099, 5'd0,  0, 99, 99, 32'h0,         0);

    // Load granted, then reset lands mid-access; the late rvalid must be dropped.
    @(posedge clk); #1;
    ex_memread = 1'b1; ex_memwrite = 1'b0; ex_aluresult = 32'h500;
    ex_rd = 5'd13; ex_regwrite = 1'b1; ex_memtoreg = 1'b1;
    mem_gnt = 1'b1; mem_rvalid = 1'b0;
    @(negedge clk);
    check("rmid_c0_stall", stall, 1'b1);
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    check("rmid_c1_stall", stall, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rmid_c2_stall", stall, 1'b0);
    check("rmid_c2_req", mem_req, 1'b0);
    check("rmid_c2_regwrite", wb_regwrite, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_bubble();
    @(negedge clk);
    check("rmid_c3_stall", stall, 1'b0);
    check("rmid_c3_rdata", wb_memreadresult, 32'h0);
    check("rmid_c3_regwrite", wb_regwrite, 1'b0);
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
    @(negedge clk);
    check("rmid_c4_stall", stall, 1'b0);
    check("rmid_c4_req", mem_req, 1'b0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("rmid_c5_rdata", wb_memreadresult, 32'h0);
    check("rmid_c5_err", err, 1'b0);
    check("rmid_c5_regwrite", wb_regwrite, 1'b0);
    model_rdata = '0;
    $display("txn %-10s reset mid-access, rdata=0x%08h", "rst_mid", wb_memreadresult);

    run_op("alu3",     0, 0, 32'h0000_0077, 32'h0,         5'd14, 1, 99, 99, 32'h0,         0);

    @(posedge clk); #1;
    set_bubble();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
